// File: rtl/adder_arbiter_if.sv
// Request/result bundle shared by the adder arbiter and its clients.
// master = requesters plus result consumer, slave = the arbiter.
interface adder_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [NREQ-1:0]    req_lock;
   logic               res_valid;
   logic               res_ready;
   logic [31:0]        res_sum;
   logic               res_carry;
   logic [IDW-1:0]     res_id;
   logic [15:0]        ops_cnt;

   modport master (
      output req_valid, req_a, req_b, req_lock, res_ready,
      input  req_ready, res_valid, res_sum, res_carry, res_id, ops_cnt
   );

   modport slave (
      input  req_valid, req_a, req_b, req_lock, res_ready,
      output req_ready, res_valid, res_sum, res_carry, res_id, ops_cnt
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-select adder among NREQ clients.
// Define ADDER_ARB_LOCK_EN to let a requester keep ownership across transfers.
module adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input logic           clk,
   input logic           rst_n,
   adder_arbiter_if.slave bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

   stage_t          state;
   logic [IDW-1:0]  last_grant;
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  cand;
   logic            found;
   logic            can_accept;
   logic            xfer;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic [31:0]     op_a;
   logic [31:0]     op_b;
   logic [31:0]     sum;
   logic [4:0]      blk_c;
   logic [31:0]     sum_q;
   logic            carry_q;
   logic [IDW-1:0]  id_q;
   logic [15:0]     ops_q;

`ifdef ADDER_ARB_LOCK_EN
   logic            locked;
   logic [IDW-1:0]  owner;

   always_comb begin
      eligible = bus.req_valid;
      if (locked) eligible = bus.req_valid & (NREQ'(1) << owner);
   end
`else
   assign eligible = bus.req_valid;
`endif

   assign can_accept = (state == EMPTY) || bus.res_ready;

   // Search upward starting one past the previous winner, wrapping at NREQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_grant) + k) % NREQ);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign grant         = (can_accept && found) ? (NREQ'(1) << winner) : '0;
   assign xfer          = can_accept && found;
   assign bus.req_ready = grant;

   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IDW'(i)) begin
            op_a = bus.req_a[32*i +: 32];
            op_b = bus.req_b[32*i +: 32];
         end
      end
   end

   // Each byte lane precomputes both carry-in cases so only the select chain ripples.
   assign blk_c[0] = 1'b0;
   for (genvar g = 0; g < 4; g++) begin : g_csel
      logic [8:0] s0;
      logic [8:0] s1;
      assign s0 = {1'b0, op_a[8*g +: 8]} + {1'b0, op_b[8*g +: 8]};
      assign s1 = {1'b0, op_a[8*g +: 8]} + {1'b0, op_b[8*g +: 8]} + 9'd1;
      assign sum[8*g +: 8] = blk_c[g] ? s1[7:0] : s0[7:0];
      assign blk_c[g+1]    = blk_c[g] ? s1[8]   : s0[8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         id_q       <= '0;
         ops_q      <= '0;
         last_grant <= IDW'(NREQ - 1);
`ifdef ADDER_ARB_LOCK_EN
         locked     <= 1'b0;
         owner      <= '0;
`endif
      end else begin
         if (xfer) begin
            state      <= FULL;
            sum_q      <= sum;
            carry_q    <= blk_c[4];
            id_q       <= winner;
            last_grant <= winner;
            ops_q      <= ops_q + 16'd1;
         end else if (bus.res_ready) begin
            state <= EMPTY;
         end
`ifdef ADDER_ARB_LOCK_EN
         // An idle owner with room available forfeits its lock.
         if (xfer) begin
            locked <= bus.req_lock[winner];
            owner  <= winner;
         end else if (locked && can_accept && !bus.req_valid[owner]) begin
            locked <= 1'b0;
         end
`endif
      end
   end

   assign bus.res_valid = (state == FULL);
   assign bus.res_sum   = sum_q;
   assign bus.res_carry = carry_q;
   assign bus.res_id    = id_q;
   assign bus.ops_cnt   = ops_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a behavioural model.
module tb_adder_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk;
   logic rst_n;

   adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: what the output stage and arbiter must hold after the last edge.
   logic            m_valid;
   logic [31:0]     m_sum;
   logic            m_carry;
   int              m_id;
   logic [15:0]     m_ops;
   int              m_last;
   bit              m_locked;
   int              m_owner;
   int              mw;
   int              mi;
   bit              m_can;
   logic [NREQ-1:0] m_ready;
   logic [32:0]     m_full;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] lock,
                                input logic rdy);
      bus.req_valid = valid;
      bus.req_lock  = lock;
      bus.res_ready = rdy;
   endtask

   task automatic setOperands(input int i, input logic [31:0] a, input logic [31:0] b);
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0000_0000;
         2:       return 32'h8000_0000;
         default: return 32'($urandom);
      endcase
   endfunction

   // Compare process: checks registered results and the grant, then advances the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_valid  = 1'b0;
         m_sum    = '0;
         m_carry  = 1'b0;
         m_id     = 0;
         m_ops    = '0;
         m_last   = NREQ - 1;
         m_locked = 1'b0;
         m_owner  = 0;
         checkOutput("rst_res_valid", 64'(bus.res_valid), 64'(0));
         checkOutput("rst_ops_cnt",   64'(bus.ops_cnt),   64'(0));
         checkOutput("rst_res_sum",   64'(bus.res_sum),   64'(0));
         checkOutput("rst_res_carry", 64'(bus.res_carry), 64'(0));
         checkOutput("rst_res_id",    64'(bus.res_id),    64'(0));
      end else begin
         checkOutput("res_valid", 64'(bus.res_valid), 64'(m_valid));
         if (m_valid) begin
            checkOutput("res_sum",   64'(bus.res_sum),   64'(m_sum));
            checkOutput("res_carry", 64'(bus.res_carry), 64'(m_carry));
            checkOutput("res_id",    64'(bus.res_id),    64'(m_id));
         end
         checkOutput("ops_cnt", 64'(bus.ops_cnt), 64'(m_ops));

         m_can = !m_valid || bus.res_ready;
         mw    = -1;
         for (int k = 1; k <= NREQ; k++) begin
            mi = (m_last + k) % NREQ;
            if (mw < 0 && bus.req_valid[mi] && (!m_locked || mi == m_owner)) mw = mi;
         end
         m_ready = (m_can && mw >= 0) ? (NREQ'(1) << mw) : '0;
         checkOutput("req_ready", 64'(bus.req_ready), 64'(m_ready));

         if (m_ready != '0) begin
            m_full  = {1'b0, bus.req_a[32*mw +: 32]} + {1'b0, bus.req_b[32*mw +: 32]};
            m_sum   = m_full[31:0];
            m_carry = m_full[32];
            m_id    = mw;
            m_last  = mw;
            m_ops   = m_ops + 16'd1;
            m_valid = 1'b1;
         end else if (bus.res_ready) begin
            m_valid = 1'b0;
         end
`ifdef ADDER_ARB_LOCK_EN
         if (m_ready != '0) begin
            m_locked = bus.req_lock[mw];
            m_owner  = mw;
         end else if (m_locked && m_can && !bus.req_valid[m_owner]) begin
            m_locked = 1'b0;
         end
`endif
      end
   end

   initial begin
      logic [NREQ-1:0] fired;
      int order [5] = '{0, 1, 2, 3, 0};

      rst_n     = 1'b0;
      bus.req_a = '0;
      bus.req_b = '0;
      applyStimulus('0, '0, 1'b0);

      // Carry out of a full-scale add from requester 0.
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      setOperands(0, 32'hFFFF_FFFF, 32'h0000_0001);
      applyStimulus(4'b0001, '0, 1'b1);
      #1 checkOutput("t1_ready", 64'(bus.req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      applyStimulus('0, '0, 1'b1);
      checkOutput("t1_valid", 64'(bus.res_valid), 64'(1));
      checkOutput("t1_sum",   64'(bus.res_sum),   64'(32'h0000_0000));
      checkOutput("t1_carry", 64'(bus.res_carry), 64'(1));
      checkOutput("t1_id",    64'(bus.res_id),    64'(0));
      checkOutput("t1_ops",   64'(bus.ops_cnt),   64'(1));

      // All requesters valid: rotation 0,1,2,3,0.
      doReset();
      for (int i = 0; i < NREQ; i++)
         setOperands(i, 32'h1000_0000 * (i + 1), 32'h0000_0011 * (i + 1));
      applyStimulus(4'b1111, '0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1 checkOutput("t2_ready", 64'(bus.req_ready), 64'(4'b0001 << order[k]));
         @(posedge clk); #1;
         checkOutput("t2_id", 64'(bus.res_id), 64'(order[k]));
      end
      checkOutput("t2_ops", 64'(bus.ops_cnt), 64'(5));

      // Stall with the stage full, then drain and reload in one cycle.
      applyStimulus(4'b1111, '0, 1'b0);
      #1 checkOutput("t3_stall_ready", 64'(bus.req_ready), 64'(0));
      @(posedge clk); #1;
      checkOutput("t3_hold_sum",   64'(bus.res_sum),   64'(32'h1000_0011));
      checkOutput("t3_hold_valid", 64'(bus.res_valid), 64'(1));
      checkOutput("t3_hold_ops",   64'(bus.ops_cnt),   64'(5));
      applyStimulus(4'b1111, '0, 1'b1);
      #1 checkOutput("t3_reload_ready", 64'(bus.req_ready), 64'(4'b0010));
      @(posedge clk); #1;
      checkOutput("t3_reload_valid", 64'(bus.res_valid), 64'(1));
      checkOutput("t3_reload_sum",   64'(bus.res_sum),   64'(32'h2000_0022));
      checkOutput("t3_reload_ops",   64'(bus.ops_cnt),   64'(6));

      // Asynchronous reset while full with req2 waiting.
      applyStimulus(4'b0100, '0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t4_rst_valid", 64'(bus.res_valid), 64'(0));
      checkOutput("t4_rst_ops",   64'(bus.ops_cnt),   64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(4'b0101, '0, 1'b1);
      #1 checkOutput("t4_prio_ready", 64'(bus.req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      checkOutput("t4_id0", 64'(bus.res_id), 64'(0));
      #1 checkOutput("t4_next_ready", 64'(bus.req_ready), 64'(4'b0100));
      @(posedge clk); #1;
      checkOutput("t4_id2", 64'(bus.res_id), 64'(2));
      applyStimulus('0, '0, 1'b1);

`ifdef ADDER_ARB_LOCK_EN
      // Requester 1 holds ownership for three transfers, then rotation resumes.
      doReset();
      applyStimulus(4'b0001, '0, 1'b1);
      @(posedge clk); #1;
      applyStimulus(4'b0111, 4'b0010, 1'b1);
      #1 checkOutput("t5_lock_a", 64'(bus.req_ready), 64'(4'b0010));
      @(posedge clk); #1;
      #1 checkOutput("t5_lock_b", 64'(bus.req_ready), 64'(4'b0010));
      @(posedge clk); #1;
      applyStimulus(4'b0111, 4'b0000, 1'b1);
      #1 checkOutput("t5_lock_c", 64'(bus.req_ready), 64'(4'b0010));
      @(posedge clk); #1;
      checkOutput("t5_lock_id", 64'(bus.res_id), 64'(1));
      applyStimulus(4'b0101, 4'b0000, 1'b1);
      #1 checkOutput("t5_after_2", 64'(bus.req_ready), 64'(4'b0100));
      @(posedge clk); #1;
      #1 checkOutput("t5_after_0", 64'(bus.req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      applyStimulus('0, '0, 1'b1);
`endif

      // Counter wrap after 65535 back-to-back transfers.
      doReset();
      applyStimulus(4'b1111, '0, 1'b1);
      repeat (65535) @(posedge clk);
      #1 checkOutput("t6_ops_max", 64'(bus.ops_cnt), 64'(16'hFFFF));
      @(posedge clk); #1;
      checkOutput("t6_ops_wrap", 64'(bus.ops_cnt), 64'(0));

      // Random traffic; operands and lock stay put until the requester is served.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         fired = rst_n ? (bus.req_valid & bus.req_ready) : '0;
         @(posedge clk); #1;
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] || fired[i]) begin
               bus.req_valid[i] = ($urandom_range(0, 9) < 6);
               bus.req_lock[i]  = ($urandom_range(0, 3) == 0);
               setOperands(i, randOperand(), randOperand());
            end
         end
         bus.res_ready = ($urandom_range(0, 3) != 0);
      end

      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus('0, '0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

- Shares one 32-bit carry-select adder among `NREQ` requesters using round-robin arbitration with valid/ready handshakes.
- Registers the sum, carry and winner ID into a single-entry output stage drained by a valid/ready consumer.
- Sits between the arithmetic clients of the datapath and the adder, so that one adder instance serves all clients at up to one operation per cycle.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `IDW`, 2: requester ID width; must equal clog2(`NREQ`).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: bit i = requester i presents an operation.
- `req_ready` out `NREQ`: bit i = requester i's operation accepted this cycle; at most one bit set.
- `req_a` in 32*`NREQ`: augends; requester i on bits [32i+31:32i].
- `req_b` in 32*`NREQ`: addends; same packing as `req_a`.
- `req_lock` in `NREQ`: bit i = requester i asks to keep ownership after this transfer; used only when the lock feature is compiled in.
- `res_valid` out 1: output stage holds a result.
- `res_ready` in 1: consumer takes the result.
- `res_sum` out 32: A+B modulo 2^32.
- `res_carry` out 1: carry out of bit 31.
- `res_id` out `IDW`: index of the requester that produced the result.
- `ops_cnt` out 16: count of accepted operations; wraps.

## Operation
Handshake and stability:
- A transfer on requester i occurs when `req_valid[i]` and `req_ready[i]` are both high.
- Once `req_valid[i]` rises, requester i holds `req_a`, `req_b` and `req_lock` stable until the transfer.

Acceptance and arbitration:
- `can_accept` = !`res_valid` | `res_ready`.
- When `can_accept` is low, all `req_ready` bits are 0.
- When `can_accept` is high, the winner is the first valid requester searching upward from `last_grant`+1 modulo `NREQ`. Only the winner's `req_ready` bit is 1.
- On a transfer:
  - `last_grant` takes the winner's index.
  - The adder result of the winner's operands, its carry and the winner's ID load into the output stage.
  - `res_valid` goes to 1.
  - `ops_cnt` increments, wrapping 0xFFFF to 0x0000.
- If `res_ready` is high and no transfer occurs, `res_valid` goes to 0.
- Simultaneous drain and accept in the same cycle is legal. The stage reloads and `res_valid` stays 1.

Output-stage state machine:
- EMPTY: `res_valid`=0.
- FULL: `res_valid`=1.
- EMPTY→FULL on a transfer.
- FULL→EMPTY on `res_ready` with no transfer.
- FULL→FULL on a stall, or on a drain with a transfer.

Reset (`rst_n` low, at any time, including mid-operation):
- `res_valid`=0, `res_sum`=0, `res_carry`=0, `res_id`=0, `ops_cnt`=0.
- `last_grant`=`NREQ`-1, so requester 0 has first priority.
- Lock cleared.
- Any in-flight result is discarded.

## Timing
- `req_ready` is combinational from `req_valid`, `res_valid`, `res_ready`, `last_grant` and the lock state. It does not depend on operand values.
- All `res_*` outputs are registered.
- Latency: a transfer in cycle N makes its result visible at `res_*` in cycle N+1.
- Throughput: one operation per cycle while `res_ready` stays high.
- Adder path: the request mux followed by the 32-bit adder must close within one clock period.
- Fairness without lock: a continuously valid requester is granted within `NREQ` transfers.

## Configuration
Macro `ADDER_ARB_LOCK_EN` controls requester locking.

When defined:
- A transfer with `req_lock[i]`=1 enters LOCKED with owner i.
- While LOCKED, only the owner may win; other requesters see `req_ready`=0.
- LOCKED exits on either of:
  - an owner transfer with `req_lock`=0;
  - any cycle where `can_accept`=1 and the owner's `req_valid`=0.
- `last_grant` updates normally during LOCKED.

When undefined:
- `req_lock` is ignored and no lock state exists.
- Arbitration is pure round-robin.

## Test plan
- Reset, then only req0 valid with A=0xFFFFFFFF, B=0x00000001 and `res_ready`=1 → `req_ready`=0001 in the first cycle; next cycle `res_sum`=0x00000000, `res_carry`=1, `res_id`=0, `ops_cnt`=1.
- All four requesters valid continuously, `res_ready`=1 → grant order 0,1,2,3,0; one result per cycle; `ops_cnt`=5 after 5 cycles.
- `res_ready`=0 with the stage FULL → `req_ready`=0000 and `res_*` held. Raise `res_ready` → drain and reload in the same cycle; `res_valid` stays 1.
- Assert `rst_n`=0 while the stage is FULL and req2 is valid → `res_valid`=0 and `ops_cnt`=0 immediately. After release, req0 has priority over req2.
- With `ADDER_ARB_LOCK_EN`, req1 performs 3 transfers with lock=1,1,0 while req0 and req2 stay valid → grants go 1,1,1, then 2, then 0.
- `ops_cnt` preloaded to 0xFFFF by 65535 transfers; one more transfer → `ops_cnt`=0x0000.
